mem_bus_arbiter: RTL and testbench

//  Shares one 32-bit memory bus between instruction fetch (IF, from pc_reg) and the MEM stage.

---
 rtl/mem_bus_arbiter_pkg.sv | 16 +
 rtl/mem_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
// Imported by the arbiter and by anything decoding its state or stall vector.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_IF   = 2'b01,
    ARB_MEM  = 2'b10
  } arb_state_t;

  // bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch and the MEM stage.
// One access at a time, MEM has priority, and a wait counter aborts stuck slaves.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              bus_err_o,
  output logic [5:0]        stall_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  arb_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic mem_pend, if_pend;
  logic grant_mem, grant_if;
  logic busy, done, expire;

  // A requester whose ack is pulsing this cycle is never re-granted.
  assign mem_pend  = mem_req_i && !mem_ack_o;
  assign if_pend   = if_req_i && !if_ack_o;
  assign grant_mem = (state == ARB_IDLE) && mem_pend;
  assign grant_if  = (state == ARB_IDLE) && !mem_pend && if_pend;
  assign busy      = (state != ARB_IDLE);
  assign done      = busy && bus_ack_i;
  assign expire    = busy && !bus_ack_i && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      grant_mem:       state_nx = ARB_MEM;
      grant_if:        state_nx = ARB_IF;
      done || expire:  state_nx = ARB_IDLE;
      default:         state_nx = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (grant_mem || grant_if || done || expire)
      cnt <= '0;
    else if (busy)
      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= 4'b0000;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
    end else if (grant_mem) begin
      bus_req_o   <= 1'b1;
      bus_we_o    <= mem_we_i;
      bus_sel_o   <= mem_sel_i;
      bus_addr_o  <= mem_addr_i;
      bus_wdata_o <= mem_wdata_i;
    end else if (grant_if) begin
      bus_req_o   <= 1'b1;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= 4'b1111;
      bus_addr_o  <= if_addr_i;
      bus_wdata_o <= '0;
    end else if (done || expire) begin
      bus_req_o   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_ack_o    <= 1'b0;
      mem_ack_o   <= 1'b0;
      if_rdata_o  <= '0;
      mem_rdata_o <= '0;
      bus_err_o   <= 1'b0;
    end else begin
      if_ack_o    <= (done || expire) && (state == ARB_IF);
      mem_ack_o   <= (done || expire) && (state == ARB_MEM);
      if_rdata_o  <= (done && state == ARB_IF) ? bus_rdata_i : '0;
      mem_rdata_o <= (done && state == ARB_MEM && !bus_we_o)
                     ? bus_rdata_i : '0;
      bus_err_o   <= expire;
    end
  end

  always_comb begin
    stall_o = STALL_NONE;
    if (!rst)          stall_o = STALL_NONE;
    else if (mem_pend) stall_o = STALL_MEM;
    else if (if_pend)  stall_o = STALL_IF;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: random IF/MEM traffic against a
// randomly slow slave, plus directed latency, write, timeout and reset cases.
module tb_mem_bus_arbiter;

  localparam int MW = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [3:0]  mem_sel_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_ack_i = 1'b0;
  logic        bus_err_o;
  logic [5:0]  stall_o;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
    .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
    .mem_ack_o(mem_ack_o), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .bus_err_o(bus_err_o), .stall_o(stall_o)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } resp_t;

  resp_t if_q[$];
  resp_t mem_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int force_d = -1;
  logic late_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cycle);
    end
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Slave model and grant checker
  logic prev_req = 1'b0, prev_mp = 1'b0, prev_ip = 1'b0, own_mem;
  int d, scyc;
  logic [31:0] sdata, snap_addr, snap_wdata;
  logic [4:0] snap_ctl;
  resp_t r_new;

  always @(negedge clk) begin
    if (!rst) begin
      prev_req = 1'b0;
      prev_mp = 1'b0;
      prev_ip = 1'b0;
      bus_ack_i = 1'b0;
    end else begin
      if (bus_req_o && !prev_req) begin
        chk("grant_has_requester", {31'b0, prev_mp | prev_ip}, 1);
        own_mem = prev_mp;
        d = (force_d >= 0) ? force_d : $urandom_range(0, 20);
        sdata = $urandom;
        scyc = 0;
        if (own_mem) begin
          chk("mem_bus_ctl", {bus_we_o, bus_sel_o}, {mem_we_i, mem_sel_i});
          chk("mem_bus_addr", bus_addr_o, mem_addr_i);
          chk("mem_bus_wdata", bus_wdata_o, mem_wdata_i);
        end else begin
          chk("if_bus_ctl", {bus_we_o, bus_sel_o}, 5'b01111);
          chk("if_bus_addr", bus_addr_o, if_addr_i);
        end
        snap_ctl = {bus_we_o, bus_sel_o};
        snap_addr = bus_addr_o;
        snap_wdata = bus_wdata_o;
        r_new.err = (d > MW);
        r_new.rdata = (d > MW || (own_mem && mem_we_i)) ? 32'h0 : sdata;
        r_new.cyc = cycle + ((d > MW) ? MW : d) + 1;
        if (own_mem) mem_q.push_back(r_new);
        else if_q.push_back(r_new);
      end else if (bus_req_o) begin
        scyc++;
        chk("bus_ctl_stable", {bus_we_o, bus_sel_o}, snap_ctl);
        chk("bus_addr_stable", bus_addr_o, snap_addr);
        chk("bus_wdata_stable", bus_wdata_o, snap_wdata);
      end
      if (bus_req_o) begin
        bus_ack_i = (scyc == d);
        bus_rdata_i = (scyc == d) ? sdata : $urandom;
      end else begin
        bus_ack_i = late_ack || ($urandom_range(0, 3) == 0);
        bus_rdata_i = $urandom;
      end
      prev_req = bus_req_o;
      prev_mp = mem_req_i && !mem_ack_o;
      prev_ip = if_req_i && !if_ack_o;
    end
  end

  // Response monitor
  resp_t r_got;
  logic [5:0] exp_stall;

  always @(negedge clk) begin
    if (rst) begin
      exp_stall = (mem_req_i && !mem_ack_o) ? 6'b011111 :
                  (if_req_i && !if_ack_o) ? 6'b000011 : 6'b000000;
      chk("stall", {26'b0, stall_o}, {26'b0, exp_stall});
      chk("single_ack", {31'b0, if_ack_o && mem_ack_o}, 0);
      if (if_ack_o) begin
        chk("if_ack_expected", if_q.size(), 1);
        if (if_q.size() > 0) begin
          r_got = if_q.pop_front();
          chk("if_rdata", if_rdata_o, r_got.rdata);
          chk("if_err", {31'b0, bus_err_o}, {31'b0, r_got.err});
          chk("if_ack_cycle", cycle, r_got.cyc);
        end
      end else begin
        chk("if_rdata_idle", if_rdata_o, 0);
      end
      if (mem_ack_o) begin
        chk("mem_ack_expected", mem_q.size(), 1);
        if (mem_q.size() > 0) begin
          r_got = mem_q.pop_front();
          chk("mem_rdata", mem_rdata_o, r_got.rdata);
          chk("mem_err", {31'b0, bus_err_o}, {31'b0, r_got.err});
          chk("mem_ack_cycle", cycle, r_got.cyc);
        end
      end else begin
        chk("mem_rdata_idle", mem_rdata_o, 0);
      end
      if (!if_ack_o && !mem_ack_o)
        chk("err_without_ack", {31'b0, bus_err_o}, 0);
    end
  end

  task automatic if_txn(input logic [31:0] a);
    int t;
    @(posedge clk); #1;
    if_req_i = 1'b1;
    if_addr_i = a;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!if_ack_o && t < 400);
    chk("if_ack_wait", {31'b0, if_ack_o}, 1);
    if_req_i = 1'b0;
    if_addr_i = $urandom;
  endtask

  task automatic mem_txn(input logic we, input logic [3:0] sel,
                         input logic [31:0] a, input logic [31:0] wd);
    int t;
    @(posedge clk); #1;
    mem_req_i = 1'b1;
    mem_we_i = we;
    mem_sel_i = sel;
    mem_addr_i = a;
    mem_wdata_i = wd;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!mem_ack_o && t < 400);
    chk("mem_ack_wait", {31'b0, mem_ack_o}, 1);
    mem_req_i = 1'b0;
    mem_we_i = $urandom;
    mem_sel_i = $urandom;
    mem_addr_i = $urandom;
    mem_wdata_i = $urandom;
  endtask

  task automatic run_if(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      if_txn($urandom);
    end
  endtask

  task automatic run_mem(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 6)) @(posedge clk);
      mem_txn($urandom, $urandom, $urandom, $urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bus_req"}, {31'b0, bus_req_o}, 0);
    chk({tag, "_acks"}, {30'b0, if_ack_o, mem_ack_o}, 0);
    chk({tag, "_bus_err"}, {31'b0, bus_err_o}, 0);
    chk({tag, "_stall"}, {26'b0, stall_o}, 0);
    chk({tag, "_mem_rdata"}, mem_rdata_o, 0);
    chk({tag, "_bus_addr"}, bus_addr_o, 0);
  endtask

  int t;

  initial begin
    if_req_i = 1'b1;
    mem_req_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    if_req_i = 1'b0;
    mem_req_i = 1'b0;
    rst = 1'b1;

    force_d = 1;
    if_txn(32'h0000_0004);
    force_d = 0;
    fork
      if_txn(32'h0000_0100);
      mem_txn(1'b0, 4'b1111, 32'h0000_0100, 32'h0);
    join
    force_d = 3;
    mem_txn(1'b1, 4'b0011, 32'h0000_0200, 32'hDEAD_BEEF);
    force_d = 30;
    if_txn(32'h0000_0008);

    force_d = -1;
    fork
      run_if(60);
      run_mem(60);
    join

    force_d = 40;
    @(posedge clk); #1;
    mem_req_i = 1'b1;
    mem_we_i = 1'b0;
    mem_addr_i = 32'h0000_0300;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!bus_req_o && t < 20);
    chk("rst_test_grant", {31'b0, bus_req_o}, 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    mem_q.delete();
    repeat (2) @(posedge clk);
    #1;
    mem_req_i = 1'b0;
    late_ack = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    late_ack = 1'b0;
    force_d = -1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_bus_req", {31'b0, bus_req_o}, 0);
    chk("if_q_drained", if_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
